// File: rtl/register_file_wb_port_pkg.sv
// Shared widths, the x0 address and the write-back acknowledge state type.
package register_file_wb_port_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = $clog2(REG_COUNT);

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } wb_ack_state_t;

endpackage

// File: rtl/register_file_wb_port_reg_scoreboard.sv
// Per-register pending-write bits: set at issue, cleared at commit, with two
// lookup ports that already account for a clear landing this cycle.
module reg_scoreboard
  import register_file_wb_port_pkg::*;
#(
  parameter int unsigned NUM_REGS = register_file_wb_port_pkg::REG_COUNT,
  parameter int unsigned ADDR_W   = register_file_wb_port_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_rd1_addr,
  input  logic [ADDR_W-1:0] i_rd2_addr,
  output logic              o_rd1_busy,
  output logic              o_rd2_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic                w_set;

  assign w_set = i_set_en && (i_set_addr != ADDR_W'(REG_ZERO));

  // Set is applied after clear so a re-issue on the commit edge keeps the bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      if (i_clr_en) begin
        r_busy[i_clr_addr] <= 1'b0;
      end
      if (w_set) begin
        r_busy[i_set_addr] <= 1'b1;
      end
    end
  end

  assign o_rd1_busy = r_busy[i_rd1_addr] &&
                      !(i_clr_en && (i_clr_addr == i_rd1_addr) &&
                        !(w_set && (i_set_addr == i_rd1_addr)));

  assign o_rd2_busy = r_busy[i_rd2_addr] &&
                      !(i_clr_en && (i_clr_addr == i_rd2_addr) &&
                        !(w_set && (i_set_addr == i_rd2_addr)));

endmodule

// File: rtl/register_file_wb_port.sv
// Integer register file on the responding side of the write-back handshake,
// with bypassed combinational read ports and a RAW scoreboard for decode.
module register_file_wb_port
  import register_file_wb_port_pkg::*;
#(
  parameter int unsigned XLEN     = register_file_wb_port_pkg::XLEN,
  parameter int unsigned NUM_REGS = register_file_wb_port_pkg::REG_COUNT,
  parameter int unsigned ADDR_W   = register_file_wb_port_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_module_enable,
  input  logic              register_write_enable,
  input  logic [ADDR_W-1:0] register_write_addr,
  input  logic [XLEN-1:0]   register_write_data,
  output logic              wb_write_complete,
  input  logic [ADDR_W-1:0] rs1_addr,
  output logic [XLEN-1:0]   rs1_data,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs2_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              rs1_busy,
  output logic              rs2_busy
);

  wb_ack_state_t   r_state;
  wb_ack_state_t   w_state_nxt;
  logic [XLEN-1:0] r_mem [NUM_REGS];
  logic            w_commit;

  assign w_commit = !reset && (r_state == IDLE) &&
                    wb_module_enable && register_write_enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ACK is held until write-back releases its enable; no commits while in ACK.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (wb_module_enable && register_write_enable) begin
          w_state_nxt = ACK;
        end
      end
      ACK: begin
        if (!wb_module_enable) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign wb_write_complete = (r_state == ACK);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_commit && (register_write_addr != ADDR_W'(REG_ZERO))) begin
      r_mem[register_write_addr] <= register_write_data;
    end
  end

  always_comb begin
    rs1_data = r_mem[rs1_addr];
    if (rs1_addr == ADDR_W'(REG_ZERO)) begin
      rs1_data = '0;
    end else if (w_commit && (register_write_addr == rs1_addr)) begin
      rs1_data = register_write_data;
    end
  end

  always_comb begin
    rs2_data = r_mem[rs2_addr];
    if (rs2_addr == ADDR_W'(REG_ZERO)) begin
      rs2_data = '0;
    end else if (w_commit && (register_write_addr == rs2_addr)) begin
      rs2_data = register_write_data;
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_set_en   (issue_valid),
    .i_set_addr (issue_dest),
    .i_clr_en   (w_commit),
    .i_clr_addr (register_write_addr),
    .i_rd1_addr (rs1_addr),
    .i_rd2_addr (rs2_addr),
    .o_rd1_busy (rs1_busy),
    .o_rd2_busy (rs2_busy)
  );

endmodule

// File: tb/tb_register_file_wb_port.sv
// Bench for register_file_wb_port: directed scenarios plus random traffic
// against an array-based model of the register file and handshake.
module tb_register_file_wb_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_module_enable;
  logic        register_write_enable;
  logic [4:0]  register_write_addr;
  logic [63:0] register_write_data;
  logic        wb_write_complete;
  logic [4:0]  rs1_addr;
  logic [63:0] rs1_data;
  logic [4:0]  rs2_addr;
  logic [63:0] rs2_data;
  logic        issue_valid;
  logic [4:0]  issue_dest;
  logic        rs1_busy;
  logic        rs2_busy;

  logic [63:0] m_mem [32];
  bit          m_busy [32];
  bit          m_ack;

  int n_total = 0;
  int n_pass  = 0;

  register_file_wb_port dut (
    .clk                   (clk),
    .reset                 (reset),
    .wb_module_enable      (wb_module_enable),
    .register_write_enable (register_write_enable),
    .register_write_addr   (register_write_addr),
    .register_write_data   (register_write_data),
    .wb_write_complete     (wb_write_complete),
    .rs1_addr              (rs1_addr),
    .rs1_data              (rs1_data),
    .rs2_addr              (rs2_addr),
    .rs2_data              (rs2_data),
    .issue_valid           (issue_valid),
    .issue_dest            (issue_dest),
    .rs1_busy              (rs1_busy),
    .rs2_busy              (rs2_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // A write is accepted only when idle with both enables high and no reset.
  function automatic bit commit_now();
    return !reset && !m_ack && wb_module_enable && register_write_enable;
  endfunction

  function automatic logic [63:0] exp_data(input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
    if (commit_now() && register_write_addr == a) return register_write_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    bit reissue;
    reissue = issue_valid && issue_dest == a && a != 5'd0;
    return m_busy[a] && !(commit_now() && register_write_addr == a && !reissue);
  endfunction

  // Advance one clock and apply the architectural effect of that edge.
  task automatic tick();
    bit c;
    @(posedge clk);
    c = commit_now();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = 64'd0;
        m_busy[i] = 1'b0;
      end
      m_ack = 1'b0;
    end else begin
      if (m_ack && !wb_module_enable) m_ack = 1'b0;
      if (c) begin
        if (register_write_addr != 5'd0) m_mem[register_write_addr] = register_write_data;
        m_busy[register_write_addr] = 1'b0;
        m_ack = 1'b1;
      end
      if (issue_valid && issue_dest != 5'd0) m_busy[issue_dest] = 1'b1;
    end
    #1;
  endtask

  task automatic quiet();
    wb_module_enable      = 1'b0;
    register_write_enable = 1'b0;
    issue_valid           = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    quiet();
    register_write_addr = 5'd0;
    register_write_data = 64'd0;
    rs1_addr = 5'd5;
    rs2_addr = 5'd9;
    issue_dest = 5'd0;
    tick();
    tick();
    n_total++;
    if (wb_write_complete !== 1'b0) $display("FAIL reset_ack got=%0b exp=0", wb_write_complete);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if (rs1_data !== 64'd0) $display("FAIL reset_rs1 got=%h exp=0", rs1_data);
    else n_pass++;
    n_total++;
    if (rs2_busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", rs2_busy);
    else n_pass++;
  endtask

  task automatic test_basic_write();
    wb_module_enable = 1'b1;
    register_write_enable = 1'b1;
    register_write_addr = 5'd5;
    register_write_data = 64'hDEAD_BEEF_0000_0001;
    rs1_addr = 5'd5;
    #1;
    n_total++;
    if (wb_write_complete !== 1'b0) $display("FAIL basic_c1_ack got=%0b exp=0", wb_write_complete);
    else n_pass++;
    tick();
    register_write_enable = 1'b0;
    register_write_data = 64'd0;
    #1;
    n_total++;
    if (wb_write_complete !== 1'b1) $display("FAIL basic_c2_ack got=%0b exp=1", wb_write_complete);
    else n_pass++;
    tick();
    wb_module_enable = 1'b0;
    #1;
    n_total++;
    if (wb_write_complete !== 1'b1) $display("FAIL basic_c3_ack got=%0b exp=1", wb_write_complete);
    else n_pass++;
    tick();
    n_total++;
    if (wb_write_complete !== 1'b0) $display("FAIL basic_c4_ack got=%0b exp=0", wb_write_complete);
    else n_pass++;
    n_total++;
    if (rs1_data !== 64'hDEAD_BEEF_0000_0001) $display("FAIL basic_read got=%h exp=deadbeef00000001", rs1_data);
    else n_pass++;
  endtask

  task automatic test_x0_write();
    wb_module_enable = 1'b1;
    register_write_enable = 1'b1;
    register_write_addr = 5'd0;
    register_write_data = 64'hFFFF;
    rs2_addr = 5'd0;
    #1;
    n_total++;
    if (rs2_data !== 64'd0) $display("FAIL x0_bypass got=%h exp=0", rs2_data);
    else n_pass++;
    tick();
    quiet();
    #1;
    n_total++;
    if (wb_write_complete !== 1'b1) $display("FAIL x0_ack got=%0b exp=1", wb_write_complete);
    else n_pass++;
    tick();
    n_total++;
    if (wb_write_complete !== 1'b0) $display("FAIL x0_release got=%0b exp=0", wb_write_complete);
    else n_pass++;
    n_total++;
    if (rs2_data !== 64'd0) $display("FAIL x0_read got=%h exp=0", rs2_data);
    else n_pass++;
  endtask

  task automatic test_bypass();
    wb_module_enable = 1'b1;
    register_write_enable = 1'b1;
    register_write_addr = 5'd7;
    register_write_data = 64'h1234;
    rs1_addr = 5'd7;
    rs2_addr = 5'd7;
    #1;
    n_total++;
    if (rs1_data !== 64'h1234) $display("FAIL bypass_rs1 got=%h exp=1234", rs1_data);
    else n_pass++;
    n_total++;
    if (rs2_data !== 64'h1234) $display("FAIL bypass_rs2 got=%h exp=1234", rs2_data);
    else n_pass++;
    tick();
    quiet();
    tick();
    n_total++;
    if (rs1_data !== 64'h1234) $display("FAIL bypass_stored got=%h exp=1234", rs1_data);
    else n_pass++;
  endtask

  task automatic test_scoreboard();
    quiet();
    issue_valid = 1'b1;
    issue_dest = 5'd9;
    rs1_addr = 5'd9;
    rs2_addr = 5'd9;
    tick();
    issue_valid = 1'b0;
    #1;
    n_total++;
    if (rs1_busy !== 1'b1) $display("FAIL sb_after_issue got=%0b exp=1", rs1_busy);
    else n_pass++;
    tick();
    n_total++;
    if (rs2_busy !== 1'b1) $display("FAIL sb_held got=%0b exp=1", rs2_busy);
    else n_pass++;
    wb_module_enable = 1'b1;
    register_write_enable = 1'b1;
    register_write_addr = 5'd9;
    register_write_data = {$urandom, $urandom};
    #1;
    n_total++;
    if (rs1_busy !== exp_busy(5'd9)) $display("FAIL sb_commit_cycle got=%0b exp=%0b", rs1_busy, exp_busy(5'd9));
    else n_pass++;
    tick();
    quiet();
    #1;
    n_total++;
    if (rs1_busy !== 1'b0) $display("FAIL sb_after_commit got=%0b exp=0", rs1_busy);
    else n_pass++;
    tick();
    issue_valid = 1'b1;
    tick();
    wb_module_enable = 1'b1;
    register_write_enable = 1'b1;
    #1;
    n_total++;
    if (rs1_busy !== 1'b1) $display("FAIL sb_reissue_cycle got=%0b exp=1", rs1_busy);
    else n_pass++;
    tick();
    quiet();
    #1;
    n_total++;
    if (rs1_busy !== 1'b1) $display("FAIL sb_reissue_kept got=%0b exp=1", rs1_busy);
    else n_pass++;
    tick();
    wb_module_enable = 1'b1;
    register_write_enable = 1'b1;
    tick();
    quiet();
    issue_valid = 1'b1;
    issue_dest = 5'd0;
    rs2_addr = 5'd0;
    tick();
    issue_valid = 1'b0;
    #1;
    n_total++;
    if (rs1_busy !== exp_busy(5'd9)) $display("FAIL sb_final_clear got=%0b exp=%0b", rs1_busy, exp_busy(5'd9));
    else n_pass++;
    n_total++;
    if (rs2_busy !== 1'b0) $display("FAIL sb_x0 got=%0b exp=0", rs2_busy);
    else n_pass++;
  endtask

  task automatic test_held_enable();
    logic [63:0] first;
    first = {$urandom, $urandom};
    wb_module_enable = 1'b1;
    register_write_enable = 1'b1;
    register_write_addr = 5'd12;
    rs1_addr = 5'd12;
    for (int i = 0; i < 4; i++) begin
      register_write_data = (i == 0) ? first : {$urandom, $urandom};
      #1;
      n_total++;
      if (wb_write_complete !== m_ack) $display("FAIL held_ack_%0d got=%0b exp=%0b", i, wb_write_complete, m_ack);
      else n_pass++;
      tick();
    end
    quiet();
    #1;
    n_total++;
    if (wb_write_complete !== 1'b1) $display("FAIL held_ack_hold got=%0b exp=1", wb_write_complete);
    else n_pass++;
    tick();
    n_total++;
    if (wb_write_complete !== 1'b0) $display("FAIL held_ack_drop got=%0b exp=0", wb_write_complete);
    else n_pass++;
    n_total++;
    if (rs1_data !== first) $display("FAIL held_data got=%h exp=%h", rs1_data, first);
    else n_pass++;
  endtask

  task automatic test_reset_in_ack();
    quiet();
    issue_valid = 1'b1;
    issue_dest = 5'd20;
    tick();
    issue_valid = 1'b0;
    wb_module_enable = 1'b1;
    register_write_enable = 1'b1;
    register_write_addr = 5'd3;
    register_write_data = {$urandom, $urandom};
    tick();
    register_write_enable = 1'b0;
    #1;
    n_total++;
    if (wb_write_complete !== 1'b1) $display("FAIL rst_ack_before got=%0b exp=1", wb_write_complete);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    quiet();
    #1;
    n_total++;
    if (wb_write_complete !== 1'b0) $display("FAIL rst_ack_after got=%0b exp=0", wb_write_complete);
    else n_pass++;
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      rs2_addr = 5'(31 - a);
      #1;
      n_total++;
      if (rs1_data !== 64'd0 || rs2_data !== 64'd0)
        $display("FAIL rst_data_%0d got=%h/%h exp=0", a, rs1_data, rs2_data);
      else n_pass++;
      n_total++;
      if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0)
        $display("FAIL rst_busy_%0d got=%0b/%0b exp=0", a, rs1_busy, rs2_busy);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [63:0] e1, e2;
    logic        b1, b2;
    for (int n = 0; n < 400; n++) begin
      wb_module_enable      = ($urandom % 4) != 0;
      register_write_enable = $urandom % 2;
      register_write_addr   = 5'($urandom % 32);
      register_write_data   = {$urandom, $urandom};
      rs1_addr    = ($urandom % 3 == 0) ? register_write_addr : 5'($urandom % 32);
      rs2_addr    = 5'($urandom % 32);
      issue_valid = ($urandom % 3) == 0;
      issue_dest  = ($urandom % 4 == 0) ? register_write_addr : 5'($urandom % 32);
      #1;
      e1 = exp_data(rs1_addr);
      e2 = exp_data(rs2_addr);
      b1 = exp_busy(rs1_addr);
      b2 = exp_busy(rs2_addr);
      n_total++;
      if (rs1_data !== e1 || rs2_data !== e2)
        $display("FAIL rnd_data_%0d got=%h/%h exp=%h/%h", n, rs1_data, rs2_data, e1, e2);
      else n_pass++;
      n_total++;
      if (rs1_busy !== b1 || rs2_busy !== b2)
        $display("FAIL rnd_busy_%0d got=%0b/%0b exp=%0b/%0b", n, rs1_busy, rs2_busy, b1, b2);
      else n_pass++;
      n_total++;
      if (wb_write_complete !== m_ack)
        $display("FAIL rnd_ack_%0d got=%0b exp=%0b", n, wb_write_complete, m_ack);
      else n_pass++;
      tick();
    end
    quiet();
    tick();
    tick();
  endtask

  initial begin
    m_ack = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 64'd0;
      m_busy[i] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_basic_write();
    test_x0_write();
    test_bypass();
    test_scoreboard();
    test_held_enable();
    test_reset_in_ack();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
